pipe_stage_reg: RTL

- Parametrised pipeline stage register for the 5-stage MIPS core; the generic successor to the fixed per-stage latches such as the MEM/WB register.
- Carries one opaque payload (DATA_W) and a set of side-effect enables (CTRL_W: GPR/HI-LO/CP0/LLbit write enables) from stage STAGE to STAGE+1.
- Handles the stall-vector hold/bubble rules, adds flush, gates enables by valid, and provides saturating bubble/hold perf counters plus a sticky protocol-error flag.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between stage STAGE and STAGE+1 of the MIPS core.
// It handles flush, bubble and hold, gates the write enables by valid, and keeps perf counters plus a sticky error flag.
module pipe_stage_reg #(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 8,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 4,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               in_valid,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic               err_o
);

    generate
        if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    logic              up;
    logic              dn;
    logic              valid_q,  valid_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic [CNT_W-1:0]  hold_q,   hold_d;
    logic              err_q,    err_d;

    assign up = stall_i[STAGE];
    assign dn = stall_i[STAGE+1];

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        bubble_d = bubble_q;
        hold_d   = hold_q;
        err_d    = err_q;

        if (flush_i || (up && !dn)) begin
            // Flush and bubble kill the content the same way; only a bubble is counted.
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
            if (!flush_i && bubble_q != {CNT_W{1'b1}}) begin
                bubble_d = bubble_q + 1'b1;
            end
        end else if (up && dn) begin
            if (hold_q != {CNT_W{1'b1}}) begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            valid_d = in_valid;
            ctrl_d  = in_valid ? in_ctrl : '0;
            data_d  = in_data;
        end

        if (!up && dn) begin
            err_d = 1'b1;
        end

        if (cnt_clr) begin
            bubble_d = '0;
            hold_d   = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            data_q   <= '0;
            bubble_q <= '0;
            hold_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
            bubble_q <= bubble_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_ctrl   = ctrl_q;
    assign out_data   = data_q;
    assign bubble_cnt = bubble_q;
    assign hold_cnt   = hold_q;
    assign err_o      = err_q;

endmodule
